dcache_responder: RTL and testbench
===================================

DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 SHALL have parameter SETS, default 64, number of direct-mapped lines (power of two, min 2).
REQ-002 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of two, min 2).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports addr  input  32, re  input  1, we  input  4, din  input  32  CPU data request (addr word-aligned; we = byte enables).
REQ-006 SHALL have ports dout  output  32, stall  output  1  CPU read data and hold-request.
REQ-007 SHALL have ports mem_req_valid  output  1, mem_req_ready  input  1, mem_req_we  output  1, mem_req_addr  output  32, mem_req_wdata  output  32, mem_req_wmask  output  4  backing-memory request.
REQ-008 SHALL have ports mem_resp_valid  input  1, mem_resp_data  input  32  backing-memory read response.

Function
REQ-009 SHALL decode addr into offset [log2(LINE_WORDS)+1:2], index (next log2(SETS) bits), tag (remaining upper bits).
REQ-010 SHALL sample a request at a rising edge in IDLE when re=1 or we!=0; we!=0 takes priority over re.
REQ-011 SHALL, on read hit, drive dout with the word on the cycle after sampling, stall=0 (1-cycle latency, no stall).
REQ-012 SHALL, on read miss, raise stall in the cycle after sampling and enter REFILL.
REQ-013 SHALL in REFILL issue LINE_WORDS single-word reads, line-aligned, offset 0 upward, at most one outstanding; beat k issued only after response k-1.
REQ-014 SHALL hold mem_req_valid with stable addr/we/wdata/wmask until mem_req_ready=1 (valid/ready handshake; accept when both high).
REQ-015 SHALL write each mem_resp_data into the line, and after the last beat set tag and valid bit, go to RESP.
REQ-016 SHALL in RESP drive requested word on dout, deassert stall, return to IDLE; stall high exactly from sample+1 through the last REFILL cycle.
REQ-017 SHALL handle writes write-through, no-allocate: hit merges din bytes per we into line; hit or miss issues one memory write (mem_req_we=1, wmask=we, wdata=din) in WRITE state.
REQ-018 SHALL keep stall high during WRITE until the write handshake completes, then return to IDLE with stall=0 next cycle.
REQ-019 SHALL ignore CPU inputs while stall=1 (CPU holds them stable).
REQ-020 SHALL have FSM states IDLE, REFILL, RESP, WRITE only; no other transitions than REQ-010..018.
REQ-021 SHALL hold dout at its last value when no read completes.

Reset
REQ-022 SHALL on reset=0 asynchronously: FSM to IDLE, all valid bits cleared, stall=0, dout=0, mem_req_valid=0, mem_req_we=0, beat counter 0.
REQ-023 SHALL abandon an in-flight refill/write on reset; line data need not be cleared; a late mem_resp_valid after reset is ignored.

Configuration
REQ-024 SHALL, when DCACHE_STATS_EN is defined, add outputs hit_count 32 and miss_count 32, incremented once per sampled read hit / read miss, cleared by reset, wrapping 0xFFFFFFFF->0.
REQ-025 SHALL, without DCACHE_STATS_EN, omit those ports and counters; all other behaviour identical.

Verification
REQ-026 Cold read 0x100, mem returns 0xA0..0xA3 for 0x100..0x10C -> 4 reads at 0x100,0x104,0x108,0x10C; stall high until done; dout=0xA0.
REQ-027 Then read 0x108 -> dout=0xA2 next cycle, stall=0, no mem request.
REQ-028 Write 0x104 din=0xDEADBEEF we=0011 (hit) -> one mem write wmask=0011; stall drops after ready; later read 0x104 -> 0xA1BEEF low bytes merged: dout=0x0000BEEF|(0xA1 & 0xFFFF0000) = 0x0000BEEF.
REQ-029 Read 0x100 then 0x100+SETS*LINE_WORDS*4 (same index) -> second misses and refills; reread 0x100 misses again.
REQ-030 Assert reset mid-REFILL (after beat 2) -> stall=0, mem_req_valid=0 immediately; next read 0x100 misses; mem_req_ready held low 5 cycles -> request fields stable throughout.

Source files
------------

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through/no-allocate data cache between a stalling CPU port and a
// single-outstanding valid/ready memory port. Optional hit/miss counters: `define DCACHE_STATS_EN.
module dcache_responder #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
`ifdef DCACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  output logic [1:0]  dbg_state
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  // Memory handshake: a request transfers on a rising edge where mem_req_valid and
  // mem_req_ready are both high; while valid is high without ready, addr/we/wdata/wmask hold.
  typedef enum logic [1:0] {IDLE = 2'd0, REFILL = 2'd1, RESP = 2'd2, WRITE = 2'd3} state_t;

  state_t             state;
  logic [31:0]        line_q [SETS][LINE_WORDS];
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [SETS-1:0]    valid_q;
  logic [OFF_W-1:0]   beat_q;
  logic [IDX_W-1:0]   req_idx_q;
  logic [OFF_W-1:0]   req_off_q;
  logic [TAG_W-1:0]   req_tag_q;

  logic [OFF_W-1:0]   cpu_off;
  logic [IDX_W-1:0]   cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic               hit;
  logic               refill_beat;
  logic               last_beat;
  logic [OFF_W-1:0]   next_beat;

  assign cpu_off     = addr[OFF_W+1:2];
  assign cpu_idx     = addr[OFF_W+IDX_W+1:OFF_W+2];
  assign cpu_tag     = addr[31:OFF_W+IDX_W+2];
  assign hit         = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  // A response is only meaningful once the current beat's request has been accepted.
  assign refill_beat = (state == REFILL) && !mem_req_valid && mem_resp_valid;
  assign last_beat   = (beat_q == OFF_W'(LINE_WORDS - 1));
  assign next_beat   = beat_q + OFF_W'(1);
  assign dbg_state   = state;

  // Line storage and tags carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (refill_beat) begin
      line_q[req_idx_q][beat_q] <= mem_resp_data;
      if (last_beat) tag_q[req_idx_q] <= req_tag_q;
    end else if (state == IDLE && we != 4'd0 && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) line_q[cpu_idx][cpu_off][8*b +: 8] <= din[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      valid_q       <= '0;
      stall         <= 1'b0;
      dout          <= 32'd0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= 32'd0;
      mem_req_wdata <= 32'd0;
      mem_req_wmask <= 4'd0;
      beat_q        <= '0;
      req_idx_q     <= '0;
      req_off_q     <= '0;
      req_tag_q     <= '0;
`ifdef DCACHE_STATS_EN
      hit_count     <= 32'd0;
      miss_count    <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (we != 4'd0) begin
            state         <= WRITE;
            stall         <= 1'b1;
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b1;
            mem_req_addr  <= addr;
            mem_req_wdata <= din;
            mem_req_wmask <= we;
          end else if (re) begin
            if (hit) begin
              dout <= line_q[cpu_idx][cpu_off];
`ifdef DCACHE_STATS_EN
              hit_count <= hit_count + 32'd1;
`endif
            end else begin
              state         <= REFILL;
              stall         <= 1'b1;
              req_idx_q     <= cpu_idx;
              req_off_q     <= cpu_off;
              req_tag_q     <= cpu_tag;
              beat_q        <= '0;
              mem_req_valid <= 1'b1;
              mem_req_we    <= 1'b0;
              mem_req_addr  <= {cpu_tag, cpu_idx, {OFF_W{1'b0}}, 2'b00};
`ifdef DCACHE_STATS_EN
              miss_count <= miss_count + 32'd1;
`endif
            end
          end
        end
        REFILL: begin
          if (mem_req_valid) begin
            if (mem_req_ready) mem_req_valid <= 1'b0;
          end else if (mem_resp_valid) begin
            if (last_beat) begin
              valid_q[req_idx_q] <= 1'b1;
              state              <= RESP;
              stall              <= 1'b0;
              beat_q             <= '0;
              // The requested word may be the one arriving right now.
              dout <= (req_off_q == beat_q) ? mem_resp_data : line_q[req_idx_q][req_off_q];
            end else begin
              beat_q        <= next_beat;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {req_tag_q, req_idx_q, next_beat, 2'b00};
            end
          end
        end
        RESP: state <= IDLE;
        WRITE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            stall         <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: directed scenarios plus random reads/writes checked against a
// flat memory image and a set/tag occupancy model; a random-ready memory responder serves the bus.
module tb_dcache_responder;

  localparam int SETS       = 64;
  localparam int LINE_WORDS = 4;
  localparam int OFF_W      = $clog2(LINE_WORDS);
  localparam int IDX_W      = $clog2(SETS);
  localparam int LOG_N      = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = 32'd0;
  logic        re = 1'b0;
  logic [3:0]  we = 4'd0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'd0;
  logic [1:0]  dbg_state;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dcache_responder #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .reset(reset), .addr(addr), .re(re), .we(we), .din(din),
    .dout(dout), .stall(stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
`ifdef DCACHE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit hold_low = 1'b0;
  int late_req = 0;

  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];
  int unsigned exp_tag [SETS];
  bit          exp_vld [SETS];
  logic [31:0] last_dout = 32'd0;
  int          hits = 0;
  int          misses = 0;

  logic [31:0] log_addr  [LOG_N];
  logic [31:0] log_wdata [LOG_N];
  logic [3:0]  log_wmask [LOG_N];
  logic        log_we    [LOG_N];
  int          log_cnt = 0;
  int          resp_cnt = 0;
  int          late_done = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a >= 32'h100 && a <= 32'h10C) return 32'hA0 + ((a - 32'h100) >> 2);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] dev_rd(input logic [31:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> (2 + OFF_W)) % SETS);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] a);
    return a >> (2 + OFF_W + IDX_W);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin : mem_responder
    bit          pend;
    int          pend_wait;
    logic [31:0] pend_data;
    pend = 1'b0;
    pend_wait = 0;
    pend_data = 32'd0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (!reset) begin
        pend = 1'b0;
        mem_req_ready = 1'b0;
      end else begin
        if (pend) begin
          if (pend_wait == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = pend_data;
            pend = 1'b0;
            resp_cnt++;
          end else begin
            pend_wait--;
          end
        end else if (late_done != late_req) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = 32'hBAD0BAD0;
          late_done++;
        end
        mem_req_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        if (mem_req_valid && mem_req_ready && log_cnt < LOG_N) begin
          log_addr[log_cnt]  = mem_req_addr;
          log_we[log_cnt]    = mem_req_we;
          log_wdata[log_cnt] = mem_req_wdata;
          log_wmask[log_cnt] = mem_req_wmask;
          log_cnt++;
          if (mem_req_we) begin
            dev_mem[mem_req_addr] = merge(dev_rd(mem_req_addr), mem_req_wdata, mem_req_wmask);
          end else begin
            pend      = 1'b1;
            pend_wait = $urandom_range(0, 2);
            pend_data = dev_rd(mem_req_addr);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (dbg_state != 2'd0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc == 50) check("idle_timeout", 32'(dbg_state), 32'd0);
  endtask

  task automatic read_op(input logic [31:0] a, input int hold);
    logic [31:0] exp_d;
    logic [31:0] base;
    bit          exp_hit;
    int          lc0;
    int          ix;
    int          cyc;
    wait_idle();
    ix      = idx_of(a);
    exp_hit = exp_vld[ix] && (exp_tag[ix] == tag_of(a));
    exp_d   = ref_rd(a);
    base    = a & ~32'(LINE_WORDS * 4 - 1);
    if (hold > 0) hold_low = 1'b1;
    lc0  = log_cnt;
    addr = a;
    re   = 1'b1;
    we   = 4'd0;
    @(negedge clk);
    re = 1'b0;
    if (exp_hit) begin
      hits++;
      check("rd_hit_stall", 32'(stall), 32'd0);
      check("rd_hit_dout", dout, exp_d);
      check("rd_hit_nomem", 32'(log_cnt - lc0), 32'd0);
    end else begin
      misses++;
      exp_vld[ix] = 1'b1;
      exp_tag[ix] = tag_of(a);
      check("rd_miss_stall", 32'(stall), 32'd1);
      for (int h = 0; h < hold; h++) begin
        check("hold_valid", 32'(mem_req_valid), 32'd1);
        check("hold_addr", mem_req_addr, base);
        check("hold_we", 32'(mem_req_we), 32'd0);
        check("hold_stall", 32'(stall), 32'd1);
        @(negedge clk);
      end
      hold_low = 1'b0;
      cyc = 0;
      while (stall && cyc < 300) begin
        @(negedge clk);
        cyc++;
      end
      check("rd_miss_done", 32'(stall), 32'd0);
      check("rd_miss_dout", dout, exp_d);
      check("rd_miss_beats", 32'(log_cnt - lc0), 32'(LINE_WORDS));
      for (int k = 0; k < LINE_WORDS; k++) begin
        if (lc0 + k < log_cnt) begin
          check("rd_beat_addr", log_addr[lc0 + k], base + 32'(4 * k));
          check("rd_beat_we", 32'(log_we[lc0 + k]), 32'd0);
        end
      end
    end
    last_dout = exp_d;
  endtask

  task automatic write_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    int lc0;
    int cyc;
    wait_idle();
    ref_mem[a] = merge(ref_rd(a), d, m);
    lc0  = log_cnt;
    addr = a;
    din  = d;
    we   = m;
    re   = 1'($urandom_range(0, 1));
    @(negedge clk);
    we = 4'd0;
    re = 1'b0;
    check("wr_stall", 32'(stall), 32'd1);
    cyc = 0;
    while (stall && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("wr_done", 32'(stall), 32'd0);
    check("wr_count", 32'(log_cnt - lc0), 32'd1);
    if (log_cnt > lc0) begin
      check("wr_addr", log_addr[lc0], a);
      check("wr_we", 32'(log_we[lc0]), 32'd1);
      check("wr_wdata", log_wdata[lc0], d);
      check("wr_wmask", 32'(log_wmask[lc0]), 32'(m));
    end
    check("wr_dout_hold", dout, last_dout);
  endtask

  task automatic reset_mid_refill(input logic [31:0] a);
    int rc0;
    int cyc;
    wait_idle();
    rc0  = resp_cnt;
    addr = a;
    re   = 1'b1;
    @(negedge clk);
    re = 1'b0;
    cyc = 0;
    while (resp_cnt - rc0 < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_two_beats", 32'(resp_cnt - rc0 >= 2), 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_valid", 32'(mem_req_valid), 32'd0);
    check("rst_we", 32'(mem_req_we), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_dout", dout, 32'd0);
    for (int s = 0; s < SETS; s++) exp_vld[s] = 1'b0;
    last_dout = 32'd0;
    hits = 0;
    misses = 0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    late_req++;
    repeat (3) @(negedge clk);
    check("late_resp_ignored", 32'(dbg_state), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] a;
    for (int s = 0; s < SETS; s++) begin
      exp_vld[s] = 1'b0;
      exp_tag[s] = 0;
    end
    repeat (2) @(negedge clk);
    check("init_stall", 32'(stall), 32'd0);
    check("init_dout", dout, 32'd0);
    check("init_valid", 32'(mem_req_valid), 32'd0);
    check("init_we", 32'(mem_req_we), 32'd0);
    check("init_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    read_op(32'h100, 0);
    read_op(32'h108, 0);
    write_op(32'h104, 32'hDEADBEEF, 4'b0011);
    read_op(32'h104, 0);
    check("merged_word", last_dout, 32'h0000BEEF);
    read_op(32'h100, 0);
    read_op(32'h100 + 32'(SETS * LINE_WORDS * 4), 0);
    read_op(32'h100, 0);
    write_op(32'h3000, 32'h12345678, 4'b1100);
    read_op(32'h3000, 0);

    reset_mid_refill(32'h200);
    read_op(32'h100, 5);
    check("post_rst_dout", last_dout, 32'h000000A0);

    for (int n = 0; n < 90; n++) begin
      int unsigned t;
      int unsigned ix;
      int unsigned off;
      t   = $urandom_range(0, 2);
      ix  = ($urandom_range(0, 7) == 0) ? SETS - 1 : $urandom_range(0, 3);
      off = $urandom_range(0, LINE_WORDS - 1);
      a   = 32'((t << (IDX_W + OFF_W + 2)) | (ix << (OFF_W + 2)) | (off << 2));
      if ($urandom_range(0, 9) < 3) write_op(a, $urandom, 4'($urandom_range(1, 15)));
      else                          read_op(a, 0);
    end
    wait_idle();

`ifdef DCACHE_STATS_EN
    check("stat_hits", hit_count, 32'(hits));
    check("stat_misses", miss_count, 32'(misses));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
